// File: rtl/mpu_alu_seq.sv
// mpu_alu_seq: operand sequencer and write-back stage for mpu_alu.
// Accepts one decoded instruction per handshake, reads up to three operands
// from an 8 x DW register file, presents them to the ALU, captures the
// result/flags and optionally writes the result back (1 instr / 3 cycles).
module mpu_alu_seq #(
    parameter int DW   = 64,
    parameter int NREG = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [3:0]    i_op,
    input  logic [1:0]    i_size,
    input  logic [2:0]    i_ra,
    input  logic [2:0]    i_rb,
    input  logic [2:0]    i_rc,
    input  logic [2:0]    i_s0,
    input  logic [2:0]    i_s1,
    input  logic [2:0]    i_s2,
    input  logic [2:0]    i_rd,
    input  logic          i_wb,
    input  logic          ld_en,
    input  logic [2:0]    ld_idx,
    input  logic [DW-1:0] ld_data,
    input  logic [2:0]    rb_idx,
    output logic [DW-1:0] rb_data,
    output logic [3:0]    alu_op,
    output logic [1:0]    alu_size,
    output logic [DW-1:0] alu_o0,
    output logic [DW-1:0] alu_o1,
    output logic [DW-1:0] alu_o2,
    output logic [2:0]    alu_s0,
    output logic [2:0]    alu_s1,
    output logic [2:0]    alu_s2,
    input  logic [DW-1:0] alu_res,
    input  logic [7:0]    alu_flags,
    output logic [DW-1:0] res,
    output logic [7:0]    flags,
    output logic          done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] regs [NREG];
    logic [2:0]    rd_q;
    logic          wb_q;
    logic          accept;

    // Host loads win over instruction issue; both only happen in IDLE.
    assign i_ready = (state == IDLE) & ~ld_en;
    assign accept  = i_valid & i_ready;
    assign done    = (state == WB);

    // Sequencer: IDLE -> EXEC -> WB -> IDLE, one instruction at a time.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= EXEC;
                EXEC:    state <= WB;
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register file: host load in IDLE, result write-back at the end of WB.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if ((state == IDLE) && ld_en) begin
            regs[ld_idx] <= ld_data;
        end else if ((state == WB) && wb_q) begin
            regs[rd_q] <= res;
        end
    end

    // Operand/control capture at accept; held stable until the next accept.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            alu_op   <= '0;
            alu_size <= '0;
            alu_o0   <= '0;
            alu_o1   <= '0;
            alu_o2   <= '0;
            alu_s0   <= '0;
            alu_s1   <= '0;
            alu_s2   <= '0;
            rd_q     <= '0;
            wb_q     <= 1'b0;
        end else if (accept) begin
            alu_op   <= i_op;
            alu_size <= i_size;
            alu_o0   <= regs[i_ra];
            alu_o1   <= regs[i_rb];
            alu_o2   <= regs[i_rc];
            alu_s0   <= i_s0;
            alu_s1   <= i_s1;
            alu_s2   <= i_s2;
            rd_q     <= i_rd;
            wb_q     <= i_wb;
        end
    end

    // Result/flags capture from the combinational ALU at the end of EXEC.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            res   <= '0;
            flags <= '0;
        end else if (state == EXEC) begin
            res   <= alu_res;
            flags <= alu_flags;
        end
    end

    // Registered readback with no bypass: same-cycle writes show next cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rb_data <= '0;
        end else begin
            rb_data <= regs[rb_idx];
        end
    end

endmodule

// File: doc/mpu_alu_seq.md
# mpu_alu_seq

Operand sequencer and write-back stage for `mpu_alu`. It accepts one decoded instruction at a time through a valid/ready handshake and reads up to three operands from an internal 8 x 64-bit register file. It drives them, together with op, size and byte selectors, onto the ALU inputs, then captures `res`/`flags` and optionally writes the result back. It sits between the MPU decoder and `mpu_alu`.

## Interface
- `DW`, 64, data width of registers and ALU operands
- `NREG`, 8, register count; index width fixed at 3 bits
- `sys_clk`  in  1  clock, all state on rising edge
- `sys_rst_n`  in  1  reset, asynchronous, active-low
- `i_valid`  in  1  instruction valid
- `i_ready`  out  1  instruction accepted when `i_valid & i_ready`
- `i_op`  in  4  ALU opcode
- `i_size`  in  2  ALU size code
- `i_ra`, `i_rb`, `i_rc`  in  3 each  source registers for o0/o1/o2
- `i_s0`, `i_s1`, `i_s2`  in  3 each  byte selectors, passed through
- `i_rd`  in  3  destination register
- `i_wb`  in  1  write result to `i_rd` when 1
- `ld_en`  in  1  host register load strobe
- `ld_idx`  in  3  load index
- `ld_data`  in  DW  load data
- `rb_idx`  in  3  readback index
- `rb_data`  out  DW  registered readback data
- `alu_op`  out  4  to ALU
- `alu_size`  out  2  to ALU
- `alu_o0`, `alu_o1`, `alu_o2`  out  DW each  to ALU
- `alu_s0`, `alu_s1`, `alu_s2`  out  3 each  to ALU
- `alu_res`  in  DW  from ALU (combinational)
- `alu_flags`  in  8  from ALU
- `res`  out  DW  captured result
- `flags`  out  8  flags register
- `done`  out  1  one-cycle pulse, result/flags valid

## Operation
- FSM states: IDLE, EXEC, WB. Reset enters IDLE.
- `i_ready` = (state == IDLE) & ~`ld_en`. Load has priority over issue.
- IDLE, `ld_en`=1: `regs[ld_idx]` <= `ld_data`. `ld_en` is ignored outside IDLE.
- IDLE, handshake: the following registers are loaded. `alu_o0`<=`regs[i_ra]`, `alu_o1`<=`regs[i_rb]`, `alu_o2`<=`regs[i_rc]`, and `alu_op/size/s0..s2` from the instruction. `i_rd` and `i_wb` are latched. Next state is EXEC.
- EXEC: ALU inputs are stable. At the end of the cycle, `res`<=`alu_res` and `flags`<=`alu_flags`. Next state is WB.
- WB: `done`=1. At the end of the cycle, if latched wb=1, `regs[rd]`<=`res`. Next state is IDLE.
- `alu_*` outputs hold their values until the next accept. `res`/`flags` hold until the next EXEC.
- No hardwired-zero register; `ra`=`rb`=`rc` is legal.
- `rb_data` <= `regs[rb_idx]` every cycle. There is no bypass: a read of a register being written this cycle returns the old value.
- Width: this block does no arithmetic. Size and selector semantics belong to the ALU.

## Timing
- Reset (`sys_rst_n`=0, any state, asynchronous): state=IDLE and all regs=0. `alu_*`, `res`, `flags`, `rb_data` and `done` are 0. `i_ready` is 1 one edge-free instant after release, provided `ld_en`=0.
- Reset mid-operation aborts the instruction: no `done` and no write-back.
- Accept on edge E0. ALU inputs are valid from E0 through the next accept. `res`/`flags` are updated at E1. `done` is high between E1 and E2. Write-back occurs at E2. The next accept happens at E3 at the earliest.
- Throughput is 1 instruction per 3 cycles. A following instruction always reads the written-back value (no hazard).
- `i_valid` may drop without acceptance. Fields are sampled only at the handshake edge.

## Test plan
- Bench ALU model: `alu_res` = `alu_o0` + `alu_o1` + `alu_o2`; `alu_flags` = {4'h0, `alu_op`}.
- Reset: hold `sys_rst_n`=0 3 cycles, then release. Expect all outputs 0, `i_ready`=1, and `rb_data`=0 for every index.
- Load r1=0x55, r2=0xAA00, r3=0x550000. Issue op=1, size=0, ra=1, rb=2, rc=3, s0/s1/s2=0/1/2, rd=4, wb=1. Required response:
  - after E0: `alu_o0/o1/o2`=0x55/0xAA00/0x550000 and `alu_s*`=0/1/2
  - `done` pulses exactly 2 cycles after accept, with `res`=0x55AA55 and `flags`=0x01
  - `rb_idx`=4 afterwards gives 0x55AA55
- Same instruction with wb=0, rd=5, op=3. Expect `done` with `flags`=0x03, and r5 stays 0.
- In IDLE, assert `ld_en` (r6=0x1) and `i_valid` in the same cycle. Expect `i_ready`=0 and r6 loaded. The instruction is accepted on the following edge.
- Back-to-back: instr A writes r7 = r1+r1+r1 = 0xFF. Instr B is held valid and reads ra=7. Expect B accepted 3 cycles after A and `alu_o0`=0xFF.
- Assert `sys_rst_n`=0 during EXEC. Expect `done` to never pulse, r4 and `flags` to be 0, and state IDLE after release.
